// File: rtl/softmax_pkg.sv
// Shared constants and fill-state encoding for the softmax vector packer.
`timescale 1ns/1ps
package softmax_pkg;
  localparam int DW         = 16;   // signed Q5.10 lane width
  localparam int LANES      = 64;
  localparam int BEAT_LANES = 4;
  localparam int FRAC_BITS  = 10;
  localparam int CNT_W      = 7;    // holds 1..LANES populated lanes

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } fill_state_e;
endpackage

// File: rtl/softmax_vec_packer_vec_out_reg.sv
// Output holding register: loads a completed vector with zero padding past the
// populated lane count and holds it until the accumulator consumes it (i_en=1).
`timescale 1ns/1ps
module vec_out_reg #(
  parameter int LANES = softmax_pkg::LANES,
  parameter int DW    = softmax_pkg::DW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [3:0]         i_mode,
  input  logic [6:0]         i_count,
  input  logic [LANES*DW-1:0] i_in0_flat,
  input  logic [LANES*DW-1:0] i_in1_flat,
  output logic               o_valid,
  output logic [3:0]         o_length_mode,
  output logic [LANES*DW-1:0] o_in0_flat,
  output logic [LANES*DW-1:0] o_in1_flat,
  output logic [6:0]         o_lane_count,
  output logic               o_slot_free
);
  logic                valid_q;
  logic [3:0]          mode_q;
  logic [6:0]          cnt_q;
  logic [LANES*DW-1:0] in0_q, in1_q;
  logic [LANES*DW-1:0] masked0, masked1;

  // Stale lanes from an earlier, longer vector live past i_count in the fill
  // buffer; zero them so the padded sum is unaffected.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      localparam logic [6:0] LANE_IDX = 7'(gi);
      assign masked0[gi*DW +: DW] = (LANE_IDX < i_count) ? i_in0_flat[gi*DW +: DW] : '0;
      assign masked1[gi*DW +: DW] = (LANE_IDX < i_count) ? i_in1_flat[gi*DW +: DW] : '0;
    end
  endgenerate

  assign o_slot_free = ~valid_q | i_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      mode_q  <= '0;
      cnt_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
    end else if (i_load) begin
      valid_q <= 1'b1;
      mode_q  <= i_mode;
      cnt_q   <= i_count;
      in0_q   <= masked0;
      in1_q   <= masked1;
    end else if (i_en) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid       = valid_q;
  assign o_length_mode = mode_q;
  assign o_lane_count  = cnt_q;
  assign o_in0_flat    = in0_q;
  assign o_in1_flat    = in1_q;
endmodule

// File: rtl/softmax_vec_packer.sv
// Packs a 4-lane beat stream into 64-lane vectors for the accumulator, with an
// early close on i_last and back-pressure while the output slot is occupied.
`timescale 1ns/1ps
module softmax_vec_packer #(
  parameter int LANES      = softmax_pkg::LANES,
  parameter int DW         = softmax_pkg::DW,
  parameter int BEAT_LANES = softmax_pkg::BEAT_LANES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_last,
  input  logic [3:0]             i_length_mode,
  input  logic [BEAT_LANES*DW-1:0] i_data0,
  input  logic [BEAT_LANES*DW-1:0] i_data1,
  output logic                   o_valid,
  output logic [3:0]             o_length_mode,
  output logic [LANES*DW-1:0]    o_in0_flat,
  output logic [LANES*DW-1:0]    o_in1_flat,
  output logic [6:0]             o_lane_count
);
  import softmax_pkg::*;

  localparam int BEATS  = LANES / BEAT_LANES;
  localparam int GW     = BEAT_LANES * DW;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fill_state_e         state_q, state_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [3:0]          mode_q, mode_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [LANES*DW-1:0] buf0_q, buf1_q;
  logic                slot_free, load, accept, closing;

  assign o_ready = ~i_rst & ((state_q != FULL) | slot_free);
  assign accept  = i_valid & o_ready;
  assign load    = (state_q == FULL) & slot_free;
  assign closing = accept & ((bidx_q == BIDX_W'(BEATS - 1)) | i_last);

  // A beat accepted in FULL starts the next vector while the held one moves
  // to the output register on the same edge; bidx_q is already 0 then.
  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (load) state_d = EMPTY;
    if (accept) begin
      if (bidx_q == '0) mode_d = i_length_mode;
      if (closing) begin
        state_d = FULL;
        bidx_d  = '0;
        cnt_d   = 7'((32'(bidx_q) + 1) * BEAT_LANES);
      end else begin
        state_d = FILL;
        bidx_d  = bidx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      bidx_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else if (accept) begin
      buf0_q[32'(bidx_q)*GW +: GW] <= i_data0;
      buf1_q[32'(bidx_q)*GW +: GW] <= i_data1;
    end
  end

  vec_out_reg #(
    .LANES (LANES),
    .DW    (DW)
  ) u_out (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_load        (load),
    .i_mode        (mode_q),
    .i_count       (cnt_q),
    .i_in0_flat    (buf0_q),
    .i_in1_flat    (buf1_q),
    .o_valid       (o_valid),
    .o_length_mode (o_length_mode),
    .o_in0_flat    (o_in0_flat),
    .o_in1_flat    (o_in1_flat),
    .o_lane_count  (o_lane_count),
    .o_slot_free   (slot_free)
  );
endmodule

// File: tb/tb_softmax_vec_packer.sv
// Scoreboard bench for softmax_vec_packer: directed scenarios plus a random
// phase, checked against a lane-array model of the packing rules.
`timescale 1ns/1ps
module tb_softmax_vec_packer;
  import softmax_pkg::*;

  localparam int GW = BEAT_LANES * DW;
  localparam int VW = LANES * DW;
  localparam int NB = LANES / BEAT_LANES;

  logic          i_clk = 1'b0;
  logic          i_rst, i_en, i_valid, i_last, o_ready, o_valid;
  logic [3:0]    i_length_mode, o_length_mode;
  logic [GW-1:0] i_data0, i_data1;
  logic [VW-1:0] o_in0_flat, o_in1_flat;
  logic [6:0]    o_lane_count;

  always #5 i_clk = ~i_clk;

  softmax_vec_packer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_last(i_last), .i_length_mode(i_length_mode), .i_data0(i_data0), .i_data1(i_data1),
    .o_valid(o_valid), .o_length_mode(o_length_mode), .o_in0_flat(o_in0_flat),
    .o_in1_flat(o_in1_flat), .o_lane_count(o_lane_count)
  );

  typedef struct packed {
    logic [3:0]    mode;
    logic [6:0]    count;
    logic [VW-1:0] in0;
    logic [VW-1:0] in1;
  } exp_t;

  exp_t        sb_q[$];
  time         cons_t[$];
  time         last_accept_t;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m0[LANES];
  logic [15:0] m1[LANES];
  int          m_n = 0;
  logic [3:0]  m_mode = '0;
  bit          en_rand = 1'b0;
  logic        en_val = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int l = 0; l < LANES; l++) begin
        if (act[l*DW +: DW] !== exp[l*DW +: DW]) begin
          $display("FAIL %s lane %0d: got %h expected %h", name, l, act[l*DW +: DW], exp[l*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Reference model: lanes collected in arrays, mode taken from the first beat,
  // everything past the populated count reads as zero.
  function automatic void model_accept(input logic [GW-1:0] d0, input logic [GW-1:0] d1,
                                       input logic [3:0] mode, input logic last);
    exp_t e;
    if (m_n == 0) m_mode = mode;
    for (int j = 0; j < BEAT_LANES; j++) begin
      m0[m_n*BEAT_LANES + j] = d0[j*DW +: DW];
      m1[m_n*BEAT_LANES + j] = d1[j*DW +: DW];
    end
    m_n++;
    if (last || m_n == NB) begin
      e.mode  = m_mode;
      e.count = 7'(m_n * BEAT_LANES);
      for (int l = 0; l < LANES; l++) begin
        e.in0[l*DW +: DW] = (l < m_n*BEAT_LANES) ? m0[l] : 16'h0;
        e.in1[l*DW +: DW] = (l < m_n*BEAT_LANES) ? m1[l] : 16'h0;
      end
      sb_q.push_back(e);
      m_n = 0;
    end
  endfunction

  // Monitor: a vector is consumed at any cycle with o_valid & i_en.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_valid && i_en) begin
        cons_t.push_back($time);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vector: got o_valid=1 count=%0d expected no pending vector", o_lane_count);
        end else begin
          mon_e = sb_q.pop_front();
          $display("vector t=%0t mode=%0d lanes=%0d", $time, o_length_mode, o_lane_count);
          chk("mode", 32'(o_length_mode), 32'(mon_e.mode));
          chk("lane_count", 32'(o_lane_count), 32'(mon_e.count));
          chk_vec("in0", o_in0_flat, mon_e.in0);
          chk_vec("in1", o_in1_flat, mon_e.in1);
        end
      end
    end
  end

  initial begin
    i_en = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_en = en_rand ? 1'($urandom_range(0, 1)) : en_val;
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic send_beat(input logic [GW-1:0] d0, input logic [GW-1:0] d1,
                           input logic [3:0] mode, input logic last);
    int tries = 0;
    bit done  = 1'b0;
    i_valid = 1'b1; i_data0 = d0; i_data1 = d1; i_length_mode = mode; i_last = last;
    while (!done) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk);
        last_accept_t = $time;
        model_accept(d0, d1, mode, last);
        done = 1'b1;
        #1;
      end else begin
        tries++;
        if (tries > 300) begin
          checks++;
          errors++;
          $display("FAIL beat_accept_timeout: got o_ready=0 for 300 cycles expected acceptance");
          done = 1'b1;
        end
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [GW-1:0] rep(input logic [15:0] v);
    return {BEAT_LANES{v}};
  endfunction

  function automatic logic [GW-1:0] rnd_beat();
    logic [GW-1:0] r;
    for (int j = 0; j < BEAT_LANES; j++) r[j*DW +: DW] = 16'($urandom);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GW-1:0] d;
    logic [GW-1:0] d2;
    time           t1;
    int            n0, len;
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_length_mode = '0;
    i_data0 = '0; i_data1 = '0;
    en_val = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_count", 32'(o_lane_count), 32'd0);
    chk_vec("rst_in1", o_in1_flat, '0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(2);

    // Full vector with i_last on the 16th beat, latency one edge after close.
    for (int b = 0; b < NB; b++) send_beat(rep(16'h0100), rep(16'h0100), 4'd0, b == NB-1);
    t1 = last_accept_t;
    n0 = cons_t.size();
    drain();
    if (cons_t.size() > n0) chk("latency", 32'(cons_t[n0] - t1), 32'd15);
    else chk("latency_seen", 32'(cons_t.size()), 32'(n0 + 1));

    // Partial vector: 8 beats, mode 1.
    for (int b = 0; b < 8; b++) send_beat(rep(16'h0200), rep(16'h0200), 4'd1, b == 7);
    drain();

    // Mode sampled on the first beat only.
    for (int b = 0; b < NB; b++) send_beat(rnd_beat(), rnd_beat(), (b == 0) ? 4'd8 : 4'd3, b == NB-1);
    drain();

    // Back-to-back: 32 continuous beats, outputs exactly 16 cycles apart.
    n0 = cons_t.size();
    for (int b = 0; b < 2*NB; b++) begin
      for (int j = 0; j < BEAT_LANES; j++) begin
        d[j*DW +: DW]  = 16'(b*BEAT_LANES + j + 16'h0100);
        d2[j*DW +: DW] = 16'(b*BEAT_LANES + j + 16'h0100);
      end
      send_beat(d, d2, 4'd2, (b == NB-1) || (b == 2*NB-1));
    end
    drain();
    if (cons_t.size() >= n0 + 2) chk("b2b_spacing", 32'(cons_t[n0+1] - cons_t[n0]), 32'd160);
    else chk("b2b_count", 32'(cons_t.size()), 32'(n0 + 2));

    // Stall: first vector held, second completes and back-pressures.
    en_val = 1'b0;
    idle(2);
    for (int b = 0; b < NB; b++) send_beat(rnd_beat(), rnd_beat(), 4'd5, b == NB-1);
    for (int b = 0; b < NB; b++) send_beat(rnd_beat(), rnd_beat(), 4'd6, b == NB-1);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("stall_ready", 32'(o_ready), 32'd0);
    chk("stall_valid", 32'(o_valid), 32'd1);
    repeat (20) @(posedge i_clk);
    @(negedge i_clk);
    chk("stall_ready_hold", 32'(o_ready), 32'd0);
    chk("stall_valid_hold", 32'(o_valid), 32'd1);
    if (sb_q.size() != 0) begin
      chk_vec("stall_in1_hold", o_in1_flat, sb_q[0].in1);
      chk("stall_mode_hold", 32'(o_length_mode), 32'(sb_q[0].mode));
    end
    @(posedge i_clk);
    #1;
    en_val = 1'b1;
    drain();

    // Asynchronous reset mid-fill discards the partial vector.
    for (int b = 0; b < 5; b++) send_beat(rnd_beat(), rnd_beat(), 4'd7, 1'b0);
    i_valid = 1'b0;
    #3;
    i_rst = 1'b1;
    m_n = 0;
    #1;
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_ready", 32'(o_ready), 32'd0);
    chk("mrst_count", 32'(o_lane_count), 32'd0);
    chk_vec("mrst_in0", o_in0_flat, '0);
    chk_vec("mrst_in1", o_in1_flat, '0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    for (int b = 0; b < NB; b++) send_beat(rep(16'hFD00), rep(16'hFD00), 4'd4, b == NB-1);
    drain();

    // Random lengths, modes, gaps and i_en.
    en_rand = 1'b1;
    for (int v = 0; v < 20; v++) begin
      len = $urandom_range(1, NB);
      for (int b = 0; b < len; b++) begin
        send_beat(rnd_beat(), rnd_beat(), 4'($urandom),
                  (b == len-1) ? ((len < NB) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    en_rand = 1'b0;
    en_val  = 1'b1;
    drain();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
